// File: rtl/segway_cmd_pkg.sv
`default_nettype none
// ============================================================================
//  Module     : segway_cmd_pkg
//  Description: Shared types and constants for the Segway command TX path:
//               sequencer state encoding and the common start/stop commands.
//  Revision   : 1.0 - initial release
// ============================================================================
package segway_cmd_pkg;

   // Sequencer states
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      SEND = 3'd2,
      WAIT = 3'd3,
      ERR  = 3'd4
   } cmd_seq_state_t;

   // Command bytes shared by the command sources and their benches
   localparam logic [7:0] CMD_START = 8'h47;  // 'G'
   localparam logic [7:0] CMD_STOP  = 8'h53;  // 'S'

endpackage : segway_cmd_pkg
`default_nettype wire

// File: rtl/cmd_tx_sequencer_fifo.sv
`default_nettype none
// ============================================================================
//  Module     : cmd_fifo
//  Description: Synchronous FIFO holding queued command bytes. Writes while
//               full and reads while empty are ignored; DEPTH must be a
//               power of two so the pointers wrap naturally.
//  Revision   : 1.0 - initial release
// ============================================================================
module cmd_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr,
   input  logic                     rd,
   input  logic [DATA_W-1:0]        din,
   output logic [DATA_W-1:0]        dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   cnt
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q;
   logic [PTR_W-1:0]  rd_ptr_q;
   logic [PTR_W:0]    cnt_q;
   logic              wr_en;
   logic              rd_en;

   // Qualify requests so a full/empty FIFO can never be corrupted
   always_comb begin
      wr_en = wr && !full;
      rd_en = rd && !empty;
   end

   // Storage: no reset needed, entries are only read after being written
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

   // Pointer and occupancy tracking; push+pop together leaves cnt unchanged
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (rd_en) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         case ({wr_en, rd_en})
            2'b10:   cnt_q <= cnt_q + (PTR_W+1)'(1);
            2'b01:   cnt_q <= cnt_q - (PTR_W+1)'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   assign dout  = mem_q[rd_ptr_q];
   assign full  = (cnt_q == (PTR_W+1)'(DEPTH));
   assign empty = (cnt_q == '0);
   assign cnt   = cnt_q;

endmodule : cmd_fifo
`default_nettype wire

// File: rtl/cmd_tx_sequencer.sv
`default_nettype none
// ============================================================================
//  Module     : cmd_tx_sequencer
//  Description: Queues command bytes and hands them to the UART one at a
//               time (one-cycle trmt, then wait for tx_done) with a per-byte
//               watchdog and a sticky timeout error latch.
//  Options    : CMD_RETRY_EN - re-send a timed-out byte up to MAX_RETRY times
//               before flagging the error.
//  Revision   : 1.0 - initial release
// ============================================================================
module cmd_tx_sequencer
   import segway_cmd_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int DEPTH       = 4,
   parameter int TIMEOUT_CYC = 1_000_000,
   parameter int MAX_RETRY   = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [DATA_W-1:0]        cmd_in,
   input  logic                     cmd_vld,
   output logic                     cmd_rdy,
   output logic [DATA_W-1:0]        tx_data,
   output logic                     trmt,
   input  logic                     tx_done,
   output logic                     busy,
   output logic                     tmo_err,
   output logic [DATA_W-1:0]        err_cmd,
   input  logic                     clr_err,
   output logic [$clog2(DEPTH):0]   fifo_cnt
);

   localparam int              WD_W    = $clog2(TIMEOUT_CYC) + 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

   cmd_seq_state_t    state_q, state_d;
   logic [DATA_W-1:0] tx_data_q, tx_data_d;
   logic [WD_W-1:0]   wdog_q, wdog_d;
   logic              tmo_err_q, tmo_err_d;
   logic [DATA_W-1:0] err_cmd_q, err_cmd_d;

   logic              fifo_rd;
   logic [DATA_W-1:0] fifo_dout;
   logic              fifo_full;
   logic              fifo_empty;

`ifdef CMD_RETRY_EN
   localparam int RT_W = $clog2(MAX_RETRY + 1) + 1;
   logic [RT_W-1:0] retry_q, retry_d;
`endif

   cmd_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .wr    (cmd_vld),
      .rd    (fifo_rd),
      .din   (cmd_in),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .cnt   (fifo_cnt)
   );

   // State, data, watchdog and error registers; reset abandons any transfer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         tx_data_q <= '0;
         wdog_q    <= '0;
         tmo_err_q <= 1'b0;
         err_cmd_q <= '0;
      end else begin
         state_q   <= state_d;
         tx_data_q <= tx_data_d;
         wdog_q    <= wdog_d;
         tmo_err_q <= tmo_err_d;
         err_cmd_q <= err_cmd_d;
      end
   end

`ifdef CMD_RETRY_EN
   // Retry counter for the byte currently in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retry_q <= '0;
      end else begin
         retry_q <= retry_d;
      end
   end
`endif

   // Next-state logic: pop, pulse trmt, wait with watchdog, report timeouts
   always_comb begin
      state_d   = state_q;
      tx_data_d = tx_data_q;
      wdog_d    = wdog_q;
      fifo_rd   = 1'b0;
      trmt      = 1'b0;
`ifdef CMD_RETRY_EN
      retry_d   = retry_q;
`endif
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            fifo_rd   = 1'b1;
            tx_data_d = fifo_dout;
`ifdef CMD_RETRY_EN
            retry_d   = '0;
`endif
            state_d   = SEND;
         end
         SEND: begin
            trmt    = 1'b1;
            wdog_d  = '0;
            state_d = WAIT;
         end
         WAIT: begin
            // Saturate rather than wrap so a huge stall cannot look fresh
            if (wdog_q != '1) begin
               wdog_d = wdog_q + WD_W'(1);
            end
            // Completion takes priority over a timeout in the same cycle
            if (tx_done) begin
               state_d = fifo_empty ? IDLE : LOAD;
            end else if (wdog_q >= WD_LAST) begin
`ifdef CMD_RETRY_EN
               if (retry_q < RT_W'(MAX_RETRY)) begin
                  retry_d = retry_q + RT_W'(1);
                  state_d = SEND;
               end else begin
                  state_d = ERR;
               end
`else
               state_d = ERR;
`endif
            end
         end
         ERR: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Sticky error latch; a new timeout beats a simultaneous clear
   always_comb begin
      tmo_err_d = tmo_err_q;
      err_cmd_d = err_cmd_q;
      if (clr_err) begin
         tmo_err_d = 1'b0;
         err_cmd_d = '0;
      end
      if (state_q == ERR) begin
         tmo_err_d = 1'b1;
         err_cmd_d = tx_data_q;
      end
   end

   assign cmd_rdy = !fifo_full;
   assign tx_data = tx_data_q;
   assign busy    = !fifo_empty || (state_q != IDLE);
   assign tmo_err = tmo_err_q;
   assign err_cmd = err_cmd_q;

endmodule : cmd_tx_sequencer
`default_nettype wire

// File: tb/tb_cmd_tx_sequencer.sv
`default_nettype none
// ============================================================================
//  Module     : tb_cmd_tx_sequencer
//  Description: Directed self-checking bench for cmd_tx_sequencer
//               (DATA_W=8, DEPTH=4, TIMEOUT_CYC=50, MAX_RETRY=2).
//  Revision   : 1.0 - initial release
// ============================================================================
module tb_cmd_tx_sequencer;
   import segway_cmd_pkg::*;

   logic       clk;
   logic       rst_n;
   logic [7:0] cmd_in;
   logic       cmd_vld;
   logic       cmd_rdy;
   logic [7:0] tx_data;
   logic       trmt;
   logic       tx_done;
   logic       busy;
   logic       tmo_err;
   logic [7:0] err_cmd;
   logic       clr_err;
   logic [2:0] fifo_cnt;

   int n_pass  = 0;
   int n_total = 0;
   int n_fail  = 0;

   logic [7:0] burst [5] = '{8'h47, 8'h53, 8'h11, 8'h22, 8'h33};

   cmd_tx_sequencer #(
      .DATA_W      (8),
      .DEPTH       (4),
      .TIMEOUT_CYC (50),
      .MAX_RETRY   (2)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cmd_in   (cmd_in),
      .cmd_vld  (cmd_vld),
      .cmd_rdy  (cmd_rdy),
      .tx_data  (tx_data),
      .trmt     (trmt),
      .tx_done  (tx_done),
      .busy     (busy),
      .tmo_err  (tmo_err),
      .err_cmd  (err_cmd),
      .clr_err  (clr_err),
      .fifo_cnt (fifo_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total = n_total + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else begin
         n_fail = n_fail + 1;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] b);
      cmd_in  = b;
      cmd_vld = 1'b1;
      step();
      cmd_vld = 1'b0;
   endtask

   task automatic wait_trmt(input int max, output int n);
      n = 0;
      while (trmt !== 1'b1 && n < max) begin
         step();
         n = n + 1;
      end
      check("trmt_seen", trmt, 1'b1);
   endtask

   // UART model: accept the next trmt, complete dly cycles later
   task automatic serve(input logic [7:0] exp, input int dly);
      int n;
      wait_trmt(10, n);
      check("serve_data", tx_data, exp);
      step();
      check("trmt_one_cycle", trmt, 1'b0);
      repeat (dly - 1) step();
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
   endtask

   initial begin
      int n;
      int pulses;
      rst_n   = 1'b0;
      cmd_in  = '0;
      cmd_vld = 1'b0;
      tx_done = 1'b0;
      clr_err = 1'b0;
      repeat (3) step();

      // ---- reset values
      check("rst_cmd_rdy", cmd_rdy, 1'b1);
      check("rst_trmt", trmt, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_tmo_err", tmo_err, 1'b0);
      check("rst_tx_data", tx_data, 8'h00);
      check("rst_err_cmd", err_cmd, 8'h00);
      check("rst_fifo_cnt", fifo_cnt, 3'd0);
      rst_n = 1'b1;
      step();

      // ---- single byte: IDLE -> LOAD -> SEND is two edges after the push
      push(CMD_START);
      check("single_cnt", fifo_cnt, 3'd1);
      check("single_busy", busy, 1'b1);
      wait_trmt(10, n);
      check("single_latency", n, 2);
      check("single_data", tx_data, 8'h47);
      pulses = 0;
      repeat (29) begin
         step();
         if (trmt) pulses = pulses + 1;
      end
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      check("single_extra_trmt", pulses, 0);
      check("single_busy_low", busy, 1'b0);
      check("single_tmo_err", tmo_err, 1'b0);
      check("single_data_hold", tx_data, 8'h47);

      // ---- burst: sequencer pops 0x47 while pushes continue, so the
      //      fifth push is the one that fills the four entries
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         cmd_in  = burst[i];
         cmd_vld = 1'b1;
         step();
         if (trmt) pulses = pulses + 1;
      end
      check("burst_first_trmt", pulses, 1);
      check("burst_inflight", tx_data, 8'h47);
      check("burst_full_cnt", fifo_cnt, 3'd4);
      check("burst_cmd_rdy", cmd_rdy, 1'b0);
      cmd_in = 8'h99;
      repeat (2) step();
      cmd_vld = 1'b0;
      check("burst_write_full", fifo_cnt, 3'd4);
      repeat (5) step();
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      for (int i = 1; i < 5; i++) serve(burst[i], 8);
      pulses = 0;
      repeat (10) begin
         step();
         if (trmt) pulses = pulses + 1;
      end
      check("burst_no_dup", pulses, 0);
      check("burst_busy_low", busy, 1'b0);

`ifdef CMD_RETRY_EN
      // ---- retry: each timeout re-sends the byte 51 edges after its trmt
      push(CMD_STOP);
      wait_trmt(10, n);
      pulses = 1;
      repeat (2) begin
         wait_trmt(60, n);
         if (n == 0) begin
            step();
            wait_trmt(60, n);
         end
         pulses = pulses + 1;
      end
      check("retry_data", tx_data, 8'h53);
      repeat (8) step();
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      check("retry_attempts", pulses, 3);
      check("retry_no_err", tmo_err, 1'b0);
      push(8'h11);
      wait_trmt(10, n);
      pulses = 0;
      n = 0;
      while (!tmo_err && n < 300) begin
         step();
         n = n + 1;
         if (trmt) pulses = pulses + 1;
      end
      check("retry_resends", pulses, 2);
      check("retry_tmo_err", tmo_err, 1'b1);
      check("retry_err_cmd", err_cmd, 8'h11);
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      check("retry_clr", tmo_err, 1'b0);
`else
      // ---- timeout: trmt sampled after edge S; WAIT from S+1 with wdog=0,
      //      wdog=49 after S+50, ERR at S+51, tmo_err visible after S+52
      push(CMD_STOP);
      push(8'h11);
      wait_trmt(10, n);
      check("tmo_data", tx_data, 8'h53);
      n = 0;
      while (!tmo_err && n < 100) begin
         step();
         n = n + 1;
      end
      check("tmo_latency", n, 52);
      check("tmo_err_cmd", err_cmd, 8'h53);
      serve(8'h11, 8);
      check("tmo_sticky", tmo_err, 1'b1);
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      check("tmo_clr", tmo_err, 1'b0);
      check("tmo_clr_cmd", err_cmd, 8'h00);
`endif

      // ---- edge race: tx_done in the terminal watchdog cycle (wdog=49)
      push(8'h22);
      wait_trmt(10, n);
      repeat (50) step();
      check("race_no_err_yet", tmo_err, 1'b0);
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      check("race_busy_low", busy, 1'b0);
      repeat (3) step();
      check("race_no_err", tmo_err, 1'b0);

      // ---- reset while waiting with three bytes queued
      push(8'hA1);
      push(8'hA2);
      push(8'hA3);
      push(8'hA4);
      repeat (3) step();
      check("rst_mid_cnt_before", fifo_cnt, 3'd3);
      rst_n = 1'b0;
      #1;
      check("rst_mid_cnt", fifo_cnt, 3'd0);
      check("rst_mid_busy", busy, 1'b0);
      check("rst_mid_rdy", cmd_rdy, 1'b1);
      check("rst_mid_data", tx_data, 8'h00);
      check("rst_mid_trmt", trmt, 1'b0);
      step();
      rst_n = 1'b1;
      pulses = 0;
      repeat (10) begin
         step();
         if (trmt) pulses = pulses + 1;
      end
      check("rst_mid_quiet", pulses, 0);
      push(8'h5A);
      serve(8'h5A, 8);
      check("rst_mid_resume", busy, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_cmd_tx_sequencer
`default_nettype wire
